// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 raster constants and the coordinate type shared with renderers
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - raster position/sync bundle; frame_tick present under VGA_SYNC_FRAME_TICK_EN
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   pixel_tick;
  coord_t coluna;
  coord_t linha;
  logic   areaAtiva;
  logic   hsync;
  logic   vsync;
`ifdef VGA_SYNC_FRAME_TICK_EN
  logic   frame_tick;

  modport master (output pixel_tick, coluna, linha, areaAtiva, hsync, vsync, frame_tick);
  modport slave  (input  pixel_tick, coluna, linha, areaAtiva, hsync, vsync, frame_tick);
`else
  modport master (output pixel_tick, coluna, linha, areaAtiva, hsync, vsync);
  modport slave  (input  pixel_tick, coluna, linha, areaAtiva, hsync, vsync);
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping position counter plus next-state active/sync decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = VGA_H_TOTAL,
  parameter int SYNC_START = VGA_H_ACTIVE + VGA_H_FP,
  parameter int SYNC_WIDTH = VGA_H_SYNC,
  parameter int ACTIVE_LEN = VGA_H_ACTIVE
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output coord_t count,
  output logic   wrap,
  output logic   active_nxt,
  output logic   sync_nxt
);

  localparam coord_t LAST       = coord_t'(TOTAL - 1);
  localparam coord_t ACT_END    = coord_t'(ACTIVE_LEN);
  localparam coord_t SYNC_FIRST = coord_t'(SYNC_START);
  localparam coord_t SYNC_END   = coord_t'(SYNC_START + SYNC_WIDTH);

  coord_t count_q;
  coord_t count_d;

  // advance on enable, wrapping at the last position; flags decode the value about to be loaded
  always_comb begin
    wrap       = en && (count_q == LAST);
    count_d    = count_q;
    if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + coord_t'(1);
    end
    active_nxt = (count_d < ACT_END);
    sync_nxt   = (count_d >= SYNC_FIRST) && (count_d < SYNC_END);
  end

  // position register parks at the last position so the first enable lands on 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= LAST;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing generator; VGA_SYNC_FRAME_TICK_EN adds a start-of-vblank frame_tick
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int CLK_DIV  = 2
) (
  input logic            clk,
  input logic            rst_n,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  // pixel-rate divider: tick on the last count, then restart
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  // divider register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  coord_t h_count, v_count;
  logic   h_wrap, v_wrap;
  logic   h_act_nxt, v_act_nxt, h_sync_nxt, v_sync_nxt;

  vga_axis_counter #(
    .TOTAL     (H_TOTAL),
    .SYNC_START(H_ACTIVE + H_FP),
    .SYNC_WIDTH(H_SYNC),
    .ACTIVE_LEN(H_ACTIVE)
  ) u_h_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (tick),
    .count     (h_count),
    .wrap      (h_wrap),
    .active_nxt(h_act_nxt),
    .sync_nxt  (h_sync_nxt)
  );

  vga_axis_counter #(
    .TOTAL     (V_TOTAL),
    .SYNC_START(V_ACTIVE + V_FP),
    .SYNC_WIDTH(V_SYNC),
    .ACTIVE_LEN(V_ACTIVE)
  ) u_v_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (h_wrap),
    .count     (v_count),
    .wrap      (v_wrap),
    .active_nxt(v_act_nxt),
    .sync_nxt  (v_sync_nxt)
  );

  logic pixel_tick_q, pixel_tick_d;
  logic area_q, area_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;

  // flags load from next-state decode on the tick, so they line up with the new position
  always_comb begin
    pixel_tick_d = tick;
    area_d       = area_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    if (tick) begin
      area_d  = h_act_nxt && v_act_nxt;
      hsync_d = h_sync_nxt ? SYNC_POL : ~SYNC_POL;
      vsync_d = v_sync_nxt ? SYNC_POL : ~SYNC_POL;
    end
  end

  // output flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_tick_q <= 1'b0;
      area_q       <= 1'b0;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
    end else begin
      pixel_tick_q <= pixel_tick_d;
      area_q       <= area_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
    end
  end

`ifdef VGA_SYNC_FRAME_TICK_EN
  logic frame_tick_q, frame_tick_d;

  // position becomes (0, V_ACTIVE) exactly when a line wraps out of the last visible line
  always_comb begin
    frame_tick_d = h_wrap && (v_count == coord_t'(V_ACTIVE - 1));
  end

  // frame tick register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= frame_tick_d;
    end
  end

  assign vga.frame_tick = frame_tick_q;
`endif

  // a frame wrap can only happen on a line wrap
  assert property (@(posedge clk) disable iff (!rst_n) v_wrap |-> h_wrap);

  assign vga.pixel_tick = pixel_tick_q;
  assign vga.coluna     = h_count;
  assign vga.linha      = v_count;
  assign vga.areaAtiva  = area_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench: full-size timing at CLK_DIV=2 and a scaled raster at CLK_DIV=1
`timescale 1ns/1ps
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] lin;
    logic       act;
    logic       hs;
    logic       vs;
    logic       ft;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen_if ifa ();
  vga_sync_gen_if ifb ();

  vga_sync_gen dut_a (
    .clk  (clk),
    .rst_n(rst_a),
    .vga  (ifa)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .CLK_DIV(1)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_b),
    .vga  (ifb)
  );

  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  int hs_low_a = 0;
  int vs_low_b = 0;
  int origin_b = 0;
  int ft_cnt_b = 0;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cmp(string p, exp_t e, exp_t s);
    chk({p, "_coluna"},    int'(s.col), int'(e.col));
    chk({p, "_linha"},     int'(s.lin), int'(e.lin));
    chk({p, "_areaAtiva"}, int'(s.act), int'(e.act));
    chk({p, "_hsync"},     int'(s.hs),  int'(e.hs));
    chk({p, "_vsync"},     int'(s.vs),  int'(e.vs));
`ifdef VGA_SYNC_FRAME_TICK_EN
    chk({p, "_frame_tick"}, int'(s.ft), int'(e.ft));
`endif
  endtask

  function automatic int pos_bits(exp_t s);
    return int'({s.col, s.lin, s.act, s.hs, s.vs});
  endfunction

  // expected raster state for the i-th tick after reset release (active-low sync)
  function automatic exp_t gen_exp(int i, int ha, int hfp, int hsw, int hbp,
                                   int va, int vfp, int vsw, int vbp);
    exp_t e;
    int ht, vt, c, l;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    c = i % ht;
    l = (i / ht) % vt;
    e.col = 10'(c);
    e.lin = 10'(l);
    e.act = (c < ha) && (l < va);
    e.hs  = !((c >= ha + hfp) && (c < ha + hfp + hsw));
    e.vs  = !((l >= va + vfp) && (l < va + vfp + vsw));
`ifdef VGA_SYNC_FRAME_TICK_EN
    e.ft  = (c == 0) && (l == va);
`else
    e.ft  = 1'b0;
`endif
    return e;
  endfunction

  // monitor A: pops the scoreboard on every pixel_tick, checks tick spacing and hold between ticks
  int   gap_a = 0;
  logic held_a = 1'b0;
  exp_t last_a;
  always @(negedge clk) begin
    exp_t s;
    s.col = ifa.coluna;
    s.lin = ifa.linha;
    s.act = ifa.areaAtiva;
    s.hs  = ifa.hsync;
    s.vs  = ifa.vsync;
`ifdef VGA_SYNC_FRAME_TICK_EN
    s.ft  = ifa.frame_tick;
`else
    s.ft  = 1'b0;
`endif
    if (!rst_a) begin
      gap_a  = 0;
      held_a = 1'b0;
    end else begin
      gap_a++;
      if (ifa.pixel_tick) begin
        chk("a_tick_gap", gap_a, 2);
        gap_a = 0;
        if (qa.size() == 0) chk("a_unexpected_tick", 1, 0);
        else cmp("a", qa.pop_front(), s);
        if (s.lin == 10'd0 && !s.hs) hs_low_a++;
      end else begin
        if (held_a) chk("a_hold", pos_bits(s), pos_bits(last_a));
        chk("a_ft_idle", int'(s.ft), 0);
      end
      last_a = s;
      held_a = 1'b1;
    end
  end

  // monitor B: same checks for the scaled raster, plus event tallies
  int   gap_b = 0;
  logic held_b = 1'b0;
  exp_t last_b;
  always @(negedge clk) begin
    exp_t s;
    s.col = ifb.coluna;
    s.lin = ifb.linha;
    s.act = ifb.areaAtiva;
    s.hs  = ifb.hsync;
    s.vs  = ifb.vsync;
`ifdef VGA_SYNC_FRAME_TICK_EN
    s.ft  = ifb.frame_tick;
`else
    s.ft  = 1'b0;
`endif
    if (!rst_b) begin
      gap_b  = 0;
      held_b = 1'b0;
    end else begin
      gap_b++;
      if (ifb.pixel_tick) begin
        chk("b_tick_gap", gap_b, 1);
        gap_b = 0;
        if (qb.size() == 0) chk("b_unexpected_tick", 1, 0);
        else cmp("b", qb.pop_front(), s);
        if (!s.vs) vs_low_b++;
        if (s.col == 10'd0 && s.lin == 10'd0) origin_b++;
        if (s.ft) ft_cnt_b++;
      end else begin
        if (held_b) chk("b_hold", pos_bits(s), pos_bits(last_b));
        chk("b_ft_idle", int'(s.ft), 0);
      end
      last_b = s;
      held_b = 1'b1;
    end
  end

  task automatic run_a();
    int n;
    repeat (10) @(negedge clk);
    chk("a_rst_coluna",     int'(ifa.coluna), 799);
    chk("a_rst_linha",      int'(ifa.linha), 524);
    chk("a_rst_areaAtiva",  int'(ifa.areaAtiva), 0);
    chk("a_rst_hsync",      int'(ifa.hsync), 1);
    chk("a_rst_vsync",      int'(ifa.vsync), 1);
    chk("a_rst_pixel_tick", int'(ifa.pixel_tick), 0);
    for (int i = 0; i < 1700; i++) qa.push_back(gen_exp(i, 640, 16, 96, 48, 480, 10, 2, 33));
    #2 rst_a = 1'b1;
    @(negedge clk); #1;
    chk("a_edge1_pixel_tick", int'(ifa.pixel_tick), 0);
    chk("a_edge1_coluna",     int'(ifa.coluna), 799);
    @(negedge clk); #1;
    chk("a_edge2_pixel_tick", int'(ifa.pixel_tick), 1);
    chk("a_edge2_coluna",     int'(ifa.coluna), 0);
    chk("a_edge2_linha",      int'(ifa.linha), 0);
    chk("a_edge2_areaAtiva",  int'(ifa.areaAtiva), 1);
    n = 0;
    while (qa.size() != 0 && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("a_drain_left", qa.size(), 0);
    #1 rst_a = 1'b0;
    #1;
    chk("a_hs_low_ticks_line0", hs_low_a, 96);
    chk("a_async_rst_coluna", int'(ifa.coluna), 799);
    chk("a_async_rst_linha",  int'(ifa.linha), 524);
  endtask

  task automatic run_b();
    int n;
    repeat (10) @(negedge clk);
    chk("b_rst_coluna",     int'(ifb.coluna), 14);
    chk("b_rst_linha",      int'(ifb.linha), 7);
    chk("b_rst_areaAtiva",  int'(ifb.areaAtiva), 0);
    chk("b_rst_pixel_tick", int'(ifb.pixel_tick), 0);
    // two and a half frames: covers the (14,7)->(0,0) wrap twice
    for (int i = 0; i < 300; i++) qb.push_back(gen_exp(i, 8, 2, 3, 2, 4, 1, 2, 1));
    #2 rst_b = 1'b1;
    n = 0;
    while (qb.size() != 0 && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("b_drain1_left", qb.size(), 0);
    #1 rst_b = 1'b0;
    #1;
    chk("b_vs_low_ticks", vs_low_b, 60);
    chk("b_origin_count", origin_b, 3);
`ifdef VGA_SYNC_FRAME_TICK_EN
    chk("b_frame_tick_count", ft_cnt_b, 2);
`endif
    repeat (3) @(negedge clk);
    // stop mid-frame at (6,2), then reset with no clock edge in between
    for (int i = 0; i < 37; i++) qb.push_back(gen_exp(i, 8, 2, 3, 2, 4, 1, 2, 1));
    #2 rst_b = 1'b1;
    n = 0;
    while (qb.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("b_drain2_left", qb.size(), 0);
    chk("b_pre_rst_coluna",    int'(ifb.coluna), 6);
    chk("b_pre_rst_linha",     int'(ifb.linha), 2);
    chk("b_pre_rst_areaAtiva", int'(ifb.areaAtiva), 1);
    #1 rst_b = 1'b0;
    #1;
    chk("b_async_rst_coluna",     int'(ifb.coluna), 14);
    chk("b_async_rst_linha",      int'(ifb.linha), 7);
    chk("b_async_rst_areaAtiva",  int'(ifb.areaAtiva), 0);
    chk("b_async_rst_hsync",      int'(ifb.hsync), 1);
    chk("b_async_rst_vsync",      int'(ifb.vsync), 1);
    chk("b_async_rst_pixel_tick", int'(ifb.pixel_tick), 0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 20; i++) qb.push_back(gen_exp(i, 8, 2, 3, 2, 4, 1, 2, 1));
    #2 rst_b = 1'b1;
    n = 0;
    while (qb.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("b_drain3_left", qb.size(), 0);
    #1 rst_b = 1'b0;
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
